sar_search: RTL

Successive-approximation controller that drives the operand side of the team's 4-bit magnitude comparator and consumes its `gt`/`lt` flags to find an unknown target value by binary search, MSB first. It sits opposite the comparator: it owns the trial operand on port A, while the external target is applied to port B. One trial bit is resolved per clock, so a full search takes WIDTH cycles, and the search ends early on an exact match.

---
 rtl/sar_search.sv | 113 +++++++++++
 1 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller.
// Drives the trial operand into an external magnitude comparator and uses
// its gt/lt flags to find the target one bit per clock, MSB first. The
// search ends early on an exact match (neither flag asserted).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; result/found hold the last search
// S_TEST | comparator flags for r_trial are sampled at every edge
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {S_IDLE, S_TEST} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_trial, w_trial_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic [WIDTH-1:0] r_result, w_result_nxt;
   logic             r_found, w_found_nxt;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_upd;

   // State and output registers; reset abandons any search in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_trial  <= '0;
         r_idx    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_found  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_trial  <= w_trial_nxt;
         r_idx    <= w_idx_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
         r_found  <= w_found_nxt;
      end
   end

   // Next-state and next-output decode; simultaneous gt and lt is treated as gt
   always_comb begin
      w_state_nxt  = r_state;
      w_trial_nxt  = r_trial;
      w_idx_nxt    = r_idx;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_result_nxt = r_result;
      w_found_nxt  = r_found;
      w_mask       = '0;
      w_mask[r_idx] = 1'b1;
      w_upd        = cmp_gt ? (r_trial & ~w_mask) : r_trial;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_trial_nxt = WIDTH'(1) << (WIDTH - 1);
               w_idx_nxt   = IW'(WIDTH - 1);
               w_busy_nxt  = 1'b1;
               w_found_nxt = 1'b0;
               w_state_nxt = S_TEST;
            end
         end
         S_TEST: begin
            if (!cmp_gt && !cmp_lt) begin
               w_result_nxt = r_trial;
               w_found_nxt  = 1'b1;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_trial_nxt  = '0;
               w_state_nxt  = S_IDLE;
            end else if (r_idx != '0) begin
               w_trial_nxt = w_upd | (w_mask >> 1);
               w_idx_nxt   = r_idx - 1'b1;
            end else begin
               w_result_nxt = w_upd;
               w_found_nxt  = 1'b0;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_trial_nxt  = '0;
               w_state_nxt  = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign trial  = r_trial;
   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign found  = r_found;

endmodule
